// File: rtl/alu_cmd_issuer.sv
// Command front end for the 4-bit ALU: accepts commands, drives registered ALU inputs,
// writes the result back to the accumulator. Optional sticky overflow: ALU_ISSUER_STICKY_OVF_EN.
module alu_cmd_issuer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_operand,
  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_cout,
  output logic             rsp_zero,
  output logic             rsp_ovf,
  output logic             rsp_err,
  output logic             ovf_sticky,
  output logic [WIDTH-1:0] acc
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] OP_LOAD = 4'h8;

  state_t           state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] operand_q;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op <= 4'h4);
  endfunction

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= '0;
      operand_q  <= '0;
      alu_opcode <= 4'h0;
      alu_a      <= '0;
      alu_b      <= '0;
      acc        <= '0;
      rsp_data   <= '0;
      rsp_cout   <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_ovf    <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q      <= cmd_op;
            operand_q <= cmd_operand;
            // LOAD and illegal ops leave the ALU inputs untouched
            if (is_alu_op(cmd_op)) begin
              alu_opcode <= cmd_op;
              alu_a      <= acc;
              alu_b      <= cmd_operand;
            end
            state <= EXEC;
          end
        end
        EXEC: begin
          state <= RESP;
          if (is_alu_op(op_q)) begin
            acc      <= alu_result;
            rsp_data <= alu_result;
            rsp_cout <= alu_cout;
            rsp_zero <= alu_zero;
            rsp_ovf  <= alu_overflow;
            rsp_err  <= 1'b0;
          end else if (op_q == OP_LOAD) begin
            acc      <= operand_q;
            rsp_data <= operand_q;
            rsp_cout <= 1'b0;
            rsp_zero <= (operand_q == '0);
            rsp_ovf  <= 1'b0;
            rsp_err  <= 1'b0;
          end else begin
            rsp_data <= acc;
            rsp_cout <= 1'b0;
            rsp_zero <= 1'b0;
            rsp_ovf  <= 1'b0;
            rsp_err  <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ISSUER_STICKY_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
    end else if (state == EXEC) begin
      if (is_alu_op(op_q) && alu_overflow) ovf_sticky <= 1'b1;
      else if (op_q == OP_LOAD)            ovf_sticky <= 1'b0;
    end
  end
`else
  assign ovf_sticky = 1'b0;
`endif

endmodule
